// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// operand width, RV32M funct3 codes, FSM encoding and op-class helpers.
package ex_mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) ||
           (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ex_mdu_seq_div_step.sv
// One radix-2 restoring division iteration (combinational).
// Ports: rem/quo/divisor in, rem_next/quo_next out.
module mdu_div_step
  import ex_mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // remainder is always below divisor, so 33 bits hold the shift
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = diff[XLEN] ? shifted[XLEN-1:0]
                               : diff[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ex_mdu_seq.sv
// Multi-cycle RV32M sequencer: registered multiplier, 32-step restoring
// divider, single-cycle special cases. Optional MDU_DIVREM_FUSE_EN keeps
// the last divide's quotient/remainder for a fast DIV<->REM pair.
// Ports: clk, rst (sync, high), Mdu_Start/Op/Rs1/Rs2, Pipe_Flush in;
//        Mdu_Stall, Mdu_Done, Mdu_Result out.
module ex_mdu_seq
  import ex_mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Mdu_Start,
  input  logic [2:0]      Mdu_Op,
  input  logic [XLEN-1:0] Mdu_Rs1,
  input  logic [XLEN-1:0] Mdu_Rs2,
  input  logic            Pipe_Flush,
  output logic            Mdu_Stall,
  output logic            Mdu_Done,
  output logic [XLEN-1:0] Mdu_Result
);

  mdu_state_t state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [2:0]      op_q;
  logic [XLEN:0]   a_q, b_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            neg_q, neg_r;

  logic            accept, sa, sb, div_zero, div_ovf;
  logic [XLEN:0]   a_ext, b_ext, mul_a, mul_b;
  logic [63:0]     prod;
  logic [2:0]      op_sel;
  logic [XLEN-1:0] mul_res, abs_a, abs_b;
  logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix, div_res;
  logic            fuse_hit;
  logic [XLEN-1:0] fuse_res;

  assign accept = (state_q == ST_IDLE) & Mdu_Start & ~Pipe_Flush;
  assign sa     = is_signed_a(Mdu_Op);
  assign sb     = is_signed_b(Mdu_Op);
  assign a_ext  = {sa & Mdu_Rs1[XLEN-1], Mdu_Rs1};
  assign b_ext  = {sb & Mdu_Rs2[XLEN-1], Mdu_Rs2};

  // with MUL_LAT==1 the product is taken straight from the inputs
  assign op_sel = (state_q == ST_IDLE) ? Mdu_Op : op_q;
  assign mul_a  = (state_q == ST_IDLE) ? a_ext : a_q;
  assign mul_b  = (state_q == ST_IDLE) ? b_ext : b_q;
  assign prod   = {{31{mul_a[XLEN]}}, mul_a}
                * {{31{mul_b[XLEN]}}, mul_b};
  assign mul_res = (op_sel == MDU_MUL) ? prod[31:0] : prod[63:32];

  assign abs_a = (sa & Mdu_Rs1[XLEN-1]) ? -Mdu_Rs1 : Mdu_Rs1;
  assign abs_b = (sb & Mdu_Rs2[XLEN-1]) ? -Mdu_Rs2 : Mdu_Rs2;

  assign div_zero = (Mdu_Rs2 == '0);
  assign div_ovf  = sa & (Mdu_Rs1 == 32'h8000_0000)
                       & (Mdu_Rs2 == 32'hFFFF_FFFF);

  mdu_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  assign q_fix   = neg_q ? -quo_n : quo_n;
  assign r_fix   = neg_r ? -rem_n : rem_n;
  assign div_res = op_q[1] ? r_fix : q_fix;

`ifdef MDU_DIVREM_FUSE_EN
  logic            f_valid, f_s;
  logic [XLEN-1:0] f_a, f_b, f_q, f_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid <= 1'b0;
      f_s     <= 1'b0;
      f_a     <= '0;
      f_b     <= '0;
      f_q     <= '0;
      f_r     <= '0;
    end else if (state_q == ST_DIV) begin
      if (Pipe_Flush) begin
        f_valid <= 1'b0;
      end else if (cnt_q == '0) begin
        f_valid <= 1'b1;
        f_a     <= a_q[XLEN-1:0];
        f_b     <= b_q[XLEN-1:0];
        f_s     <= ~op_q[0];
        f_q     <= q_fix;
        f_r     <= r_fix;
      end
    end
  end

  assign fuse_hit = f_valid & (Mdu_Rs1 == f_a) & (Mdu_Rs2 == f_b)
                  & (sa == f_s);
  assign fuse_res = Mdu_Op[1] ? f_r : f_q;
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_div(Mdu_Op)) begin
            if (MUL_LAT == 1) begin
              state_d = ST_DONE;
              res_d   = mul_res;
            end else begin
              state_d = ST_MUL;
              cnt_d   = 5'(MUL_LAT - 1);
            end
          end else if (div_zero) begin
            state_d = ST_DONE;
            res_d   = Mdu_Op[1] ? Mdu_Rs1 : '1;
          end else if (div_ovf) begin
            state_d = ST_DONE;
            res_d   = Mdu_Op[1] ? '0 : 32'h8000_0000;
          end else if (fuse_hit) begin
            state_d = ST_DONE;
            res_d   = fuse_res;
          end else begin
            state_d = ST_DIV;
            cnt_d   = 5'd31;
          end
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_d == '0) begin
          state_d = ST_DONE;
          res_d   = mul_res;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          res_d   = div_res;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (Pipe_Flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      if (accept) begin
        op_q  <= Mdu_Op;
        a_q   <= a_ext;
        b_q   <= b_ext;
        rem_q <= '0;
        quo_q <= abs_a;
        dvs_q <= abs_b;
        neg_q <= sa & (Mdu_Rs1[XLEN-1] ^ Mdu_Rs2[XLEN-1]);
        neg_r <= sa & Mdu_Rs1[XLEN-1];
      end else if (state_q == ST_DIV) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
      end
    end
  end

  assign Mdu_Done   = (state_q == ST_DONE) & ~Pipe_Flush;
  assign Mdu_Stall  = Mdu_Start & ~Mdu_Done;
  assign Mdu_Result = res_q;

endmodule

// File: doc/ex_mdu_seq.md
Name: ex_mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the execute stage. It takes RV32M operations out of the single-cycle ALU path and runs them in three ways:
- a registered multiplier with fixed latency;
- a radix-2 restoring divider taking 32 iterations;
- a fast path for RISC-V special cases.

While an operation is in flight it stalls the IDEX/EXMem pipeline registers. It returns exactly one result per accepted operation.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
MUL_LAT, 2, cycles from accept to Mdu_Done for MUL* ops (range 1..4)

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  synchronous, active-high reset
Mdu_Start  in  1  EX holds a valid M-extension op; held high with stable operands until Mdu_Done
Mdu_Op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
Mdu_Rs1  in  32  operand a (forwarded rs1)
Mdu_Rs2  in  32  operand b (forwarded rs2)
Pipe_Flush  in  1  branch/trap flush of the EX instruction
Mdu_Stall  out  1  freeze PC/IFID/IDEX; equals Mdu_Start & ~Mdu_Done
Mdu_Done  out  1  one-cycle pulse; Mdu_Result valid this cycle
Mdu_Result  out  32  result, held until the next accept

Behaviour:
- Reset: state IDLE, counter 0, Mdu_Done 0, Mdu_Result 0, all internal operand registers 0. A reset mid-operation abandons the op; no Done is issued.
- States: IDLE, MUL, DIV, DONE.
- IDLE: acceptance and special cases
  - Mdu_Start=1 and no flush -> accept: latch op, operands and sign flags.
  - Op<4 -> MUL with counter=MUL_LAT-1. If MUL_LAT==1, go straight to DONE.
  - Op>=4 and Rs2==0 -> DONE. Quotient 0xFFFFFFFF; remainder = Rs1.
  - DIV/REM with Rs1==0x80000000 and Rs2==0xFFFFFFFF -> DONE. Quotient 0x80000000; remainder 0.
  - Any other divide -> DIV. Latch |Rs1| and |Rs2|; signedness applies only to ops 4 and 6. Counter=31.
- MUL: multiply
  - Full 64-bit product formed from sign/zero-extended 33-bit operands.
  - Pipeline registers are internal; counter decrements each cycle; ->DONE when counter==0.
  - MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- DIV: divide
  - One restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor, set quotient LSB.
  - ->DONE after the step with counter==0, i.e. 32 steps.
  - On that transition apply sign fix: quotient negated if dividend sign != divisor sign; remainder takes the dividend sign.
- DONE: Mdu_Done = (state==DONE) & ~Pipe_Flush. Next state is always IDLE.
- Latency, counted from the cycle Start is first seen in IDLE (cycle 0):
  - Done at cycle MUL_LAT for MUL*.
  - Done at cycle 33 for a normal divide.
  - Done at cycle 1 for divide-by-zero or overflow.
- Start handling: Start while not IDLE is ignored, because operands are already latched. The pipeline advances at the end of the Done cycle, so the next op's Start is seen in IDLE on the following cycle. There is no back-to-back accept in DONE.
- Flush: Pipe_Flush in any state -> IDLE next cycle, no Done, Mdu_Result unchanged. Flush in IDLE with Start=1 -> not accepted.
- Mdu_Result is updated only on entry to DONE.

Optional Feature:
MDU_DIVREM_FUSE_EN:
- Defined: keep the last completed divide's operands, signedness, quotient and remainder, plus a valid bit.
  - In IDLE, a divide-class op whose Rs1, Rs2 and signed flag match the stored entry skips to DONE with the stored value. Done at cycle 1; this covers DIV followed by REM and vice versa.
  - The valid bit is cleared by rst and by any flush during DIV.
- Undefined: no storage; every normal divide takes 33 cycles.

Decomposition:
- Package ex_mdu_pkg holds:
  - XLEN;
  - the funct3 op localparams (MDU_MUL..MDU_REMU);
  - the state encoding (IDLE/MUL/DIV/DONE);
  - helpers is_div(op), is_signed_a(op), is_signed_b(op).
- One natural sub-module, mdu_div_step: purely combinational single restoring iteration, (rem,quo,divisor) -> (rem',quo'). Instantiated once in DIV.

Test Plan:
- MUL, Rs1=0xFFFFFFFF, Rs2=0x00000002, MUL_LAT=2 -> Done at cycle 2, Result 0xFFFFFFFE; Stall high cycles 0-1.
- MULH/MULHSU/MULHU, Rs1=0x80000000, Rs2=0xFFFFFFFF -> results 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV, Rs1=-7 (0xFFFFFFF9), Rs2=2 -> Done at cycle 33, Result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF; with the fuse feature enabled, Done at cycle 1.
- DIVU, Rs2=0 -> Done at cycle 1, Result 0xFFFFFFFF. REM, Rs1=0x80000000, Rs2=0xFFFFFFFF -> Done at cycle 1, Result 0.
- DIV started, Pipe_Flush at cycle 10 -> IDLE at cycle 11, no Done. A new DIVU 100/7 then starts -> Done 33 cycles later, Result 14.
- rst asserted at cycle 5 of a DIV -> next cycle: IDLE, Done 0, Result 0, Stall follows Start only.
